// File: rtl/te_pkg.sv
// Shared types and default parameters for the transmission-estimate multiplier.
package te_pkg;

  localparam int TE_LANES  = 1;
  localparam int TE_FC_W   = 8;
  localparam int TE_FRAC_W = 14;
  localparam int TE_T0     = 1638;

  typedef enum logic {
    TE_MODE_PRODUCT = 1'b0,
    TE_MODE_TRANS   = 1'b1
  } te_mode_e;

endpackage

// File: rtl/te_multiplier_pipe_if.sv
// Stream, Inv_Ac load and output bundle for te_multiplier_pipe.
interface te_multiplier_pipe_if
  import te_pkg::*;
#(
  parameter int LANES  = TE_LANES,
  parameter int FC_W   = TE_FC_W,
  parameter int FRAC_W = TE_FRAC_W
) ();

  te_mode_e                    mode;
  logic [FRAC_W-1:0]           inv_ac_in;
  logic                        inv_ac_load;
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_sof;
  logic [LANES*FC_W-1:0]       in_fc;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_sof;
  logic [LANES*FRAC_W-1:0]     out_data;
  logic [LANES-1:0]            out_sat;

  modport master (
    output mode, inv_ac_in, inv_ac_load, in_valid, in_sof, in_fc, out_ready,
    input  in_ready, out_valid, out_sof, out_data, out_sat
  );

  modport slave (
    input  mode, inv_ac_in, inv_ac_load, in_valid, in_sof, in_fc, out_ready,
    output in_ready, out_valid, out_sof, out_data, out_sat
  );

endinterface

// File: rtl/te_multiplier_pipe_lane.sv
// One lane of stage 2: saturate the product, optionally invert and floor at T0.
module te_lane
  import te_pkg::*;
#(
  parameter int FC_W   = TE_FC_W,
  parameter int FRAC_W = TE_FRAC_W,
  parameter int T0     = TE_T0
) (
  input  logic [FC_W+FRAC_W-1:0] prod,
  input  te_mode_e               mode,
  output logic [FRAC_W-1:0]      data,
  output logic                   sat
);

  localparam logic [FRAC_W-1:0] ONE_Q = {FRAC_W{1'b1}};
  localparam logic [FRAC_W-1:0] T0_Q  = FRAC_W'(T0);

  logic [FRAC_W-1:0] ps;
  logic [FRAC_W-1:0] t;

  always_comb begin
    sat  = |prod[FC_W+FRAC_W-1:FRAC_W];
    ps   = sat ? ONE_Q : prod[FRAC_W-1:0];
    // ps never exceeds ONE_Q, so the subtraction cannot underflow.
    t    = ONE_Q - ps;
    data = ps;
    if (mode == TE_MODE_TRANS) begin
      data = (t < T0_Q) ? T0_Q : t;
    end
  end

endmodule

// File: rtl/te_multiplier_pipe.sv
// Two-stage ready/valid multiplier computing w*Fc/Ac per lane, with a frame-aligned
// Inv_Ac shadow register so the scale factor only changes on start-of-frame beats.
module te_multiplier_pipe
  import te_pkg::*;
#(
  parameter int LANES  = TE_LANES,
  parameter int FC_W   = TE_FC_W,
  parameter int FRAC_W = TE_FRAC_W,
  parameter int T0     = TE_T0
) (
  input logic                 clk,
  input logic                 rst,
  te_multiplier_pipe_if.slave bus
);

  localparam int P_W = FC_W + FRAC_W;

  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_sof_q,   s1_sof_d;
  te_mode_e                s1_mode_q,  s1_mode_d;
  logic [P_W-1:0]          s1_prod_q [LANES];
  logic [P_W-1:0]          s1_prod_d [LANES];

  logic                    s2_valid_q, s2_valid_d;
  logic                    s2_sof_q,   s2_sof_d;
  logic [LANES*FRAC_W-1:0] s2_data_q,  s2_data_d;
  logic [LANES-1:0]        s2_sat_q,   s2_sat_d;

  logic [FRAC_W-1:0]       active_q, active_d;
  logic [FRAC_W-1:0]       pend_q,   pend_d;
  logic                    pend_flag_q, pend_flag_d;

  logic                    s1_load, s2_load, accept;
  logic [FRAC_W-1:0]       beat_inv;
  logic [LANES*FRAC_W-1:0] lane_data;
  logic [LANES-1:0]        lane_sat;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    s2_load = !s2_valid_q || bus.out_ready;
    s1_load = !s1_valid_q || s2_load;
    accept  = bus.in_valid && s1_load;
  end

  assign bus.in_ready = s1_load;

  // An sof beat takes the freshest scale: a same-cycle load beats the pending copy.
  always_comb begin
    active_d    = active_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    beat_inv    = active_q;
    if (bus.inv_ac_load) begin
      pend_d      = bus.inv_ac_in;
      pend_flag_d = 1'b1;
    end
    if (accept && bus.in_sof) begin
      if (bus.inv_ac_load) begin
        active_d    = bus.inv_ac_in;
        beat_inv    = bus.inv_ac_in;
        pend_flag_d = 1'b0;
      end else if (pend_flag_q) begin
        active_d    = pend_q;
        beat_inv    = pend_q;
        pend_flag_d = 1'b0;
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sof_d   = s1_sof_q;
    s1_mode_d  = s1_mode_q;
    s1_prod_d  = s1_prod_q;
    if (s1_load) begin
      s1_valid_d = bus.in_valid;
    end
    if (accept) begin
      s1_sof_d  = bus.in_sof;
      s1_mode_d = bus.mode;
      for (int i = 0; i < LANES; i++) begin
        s1_prod_d[i] = P_W'(bus.in_fc[i*FC_W +: FC_W]) * P_W'(beat_inv);
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    te_lane #(
      .FC_W   (FC_W),
      .FRAC_W (FRAC_W),
      .T0     (T0)
    ) u_lane (
      .prod (s1_prod_q[g]),
      .mode (s1_mode_q),
      .data (lane_data[g*FRAC_W +: FRAC_W]),
      .sat  (lane_sat[g])
    );
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sof_d   = s2_sof_q;
    s2_data_d  = s2_data_q;
    s2_sat_d   = s2_sat_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sof_d  = s1_sof_q;
        s2_data_d = lane_data;
        s2_sat_d  = lane_sat;
      end
    end
  end

  // NOTE: datapath registers are reset as well as the valids, so outputs read 0 while in reset.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values, independent of order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_mode_q   <= TE_MODE_PRODUCT;
      for (int i = 0; i < LANES; i++) begin
        s1_prod_q[i] <= '0;
      end
      s2_valid_q  <= 1'b0;
      s2_sof_q    <= 1'b0;
      s2_data_q   <= '0;
      s2_sat_q    <= '0;
      active_q    <= '0;
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sof_q    <= s1_sof_d;
      s1_mode_q   <= s1_mode_d;
      s1_prod_q   <= s1_prod_d;
      s2_valid_q  <= s2_valid_d;
      s2_sof_q    <= s2_sof_d;
      s2_data_q   <= s2_data_d;
      s2_sat_q    <= s2_sat_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_sof   = s2_sof_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_sat   = s2_sat_q;

endmodule

// File: tb/tb_te_multiplier_pipe.sv
// Scoreboard bench for te_multiplier_pipe: a single-lane and a four-lane instance.
module tb_te_multiplier_pipe;
  import te_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  te_multiplier_pipe_if #(.LANES(1), .FC_W(8), .FRAC_W(14)) bus1 ();
  te_multiplier_pipe_if #(.LANES(4), .FC_W(8), .FRAC_W(14)) bus4 ();

  te_multiplier_pipe #(.LANES(1), .FC_W(8), .FRAC_W(14), .T0(1638)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );
  te_multiplier_pipe #(.LANES(4), .FC_W(8), .FRAC_W(14), .T0(1638)) dut4 (
    .clk (clk), .rst (rst), .bus (bus4)
  );

  typedef struct {
    logic [55:0] data;
    logic [3:0]  sat;
    logic        sof;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send1(input logic [7:0] fc, input logic sof, input te_mode_e mode,
                       input logic load, input logic [13:0] inv,
                       input logic [13:0] exp_data, input logic exp_sat, input int lat);
    exp_t e;
    int   n;
    logic done;
    n = 0;
    done = 1'b0;
    bus1.in_fc = fc;  bus1.in_sof = sof;  bus1.mode = mode;
    bus1.inv_ac_load = load;  bus1.inv_ac_in = inv;  bus1.in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus1.in_ready) done = 1'b1;
      else if (++n > 50) begin
        fail_now("send1_in_ready_timeout");
        done = 1'b1;
      end
    end
    if (n <= 50) begin
      e.data = 56'(exp_data);  e.sat = 4'(exp_sat);  e.sof = sof;
      e.acc = cyc;  e.lat = lat;
      q1.push_back(e);
    end
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;  bus1.inv_ac_load = 1'b0;  bus1.in_sof = 1'b0;
  endtask

  task automatic send4(input logic [31:0] fc, input logic [13:0] inv,
                       input logic [55:0] exp_data, input logic [3:0] exp_sat);
    exp_t e;
    int   n;
    logic done;
    n = 0;
    done = 1'b0;
    bus4.in_fc = fc;  bus4.in_sof = 1'b1;  bus4.mode = TE_MODE_PRODUCT;
    bus4.inv_ac_load = 1'b1;  bus4.inv_ac_in = inv;  bus4.in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus4.in_ready) done = 1'b1;
      else if (++n > 50) begin
        fail_now("send4_in_ready_timeout");
        done = 1'b1;
      end
    end
    if (n <= 50) begin
      e.data = exp_data;  e.sat = exp_sat;  e.sof = 1'b1;  e.acc = cyc;  e.lat = 2;
      q4.push_back(e);
    end
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;  bus4.inv_ac_load = 1'b0;  bus4.in_sof = 1'b0;
  endtask

  task automatic load1(input logic [13:0] inv);
    bus1.inv_ac_in = inv;  bus1.inv_ac_load = 1'b1;
    @(posedge clk); #1;
    bus1.inv_ac_load = 1'b0;
  endtask

  task automatic drain(input logic which4);
    int n;
    n = 0;
    while ((which4 ? q4.size() : q1.size()) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 100) fail_now(which4 ? "drain4_timeout" : "drain1_timeout");
  endtask

  // Single-lane monitor: pops on each transfer, checks hold stability while stalled.
  initial begin : mon1
    exp_t        e;
    logic        stall;
    logic [13:0] hd;
    logic        hs, hf;
    stall = 1'b0;  hd = '0;  hs = 1'b0;  hf = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst || !bus1.out_valid) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_data", 64'(bus1.out_data), 64'(hd));
          check("hold_sat",  64'(bus1.out_sat),  64'(hs));
          check("hold_sof",  64'(bus1.out_sof),  64'(hf));
        end
        if (bus1.out_ready) begin
          stall = 1'b0;
          if (q1.size() == 0) fail_now("unexpected_out1");
          else begin
            e = q1.pop_front();
            check("out1_data", 64'(bus1.out_data), 64'(e.data[13:0]));
            check("out1_sat",  64'(bus1.out_sat),  64'(e.sat[0]));
            check("out1_sof",  64'(bus1.out_sof),  64'(e.sof));
            if (e.lat >= 0) check("out1_latency", 64'(cyc - e.acc), 64'(e.lat));
          end
        end else begin
          stall = 1'b1;
          hd = bus1.out_data;  hs = bus1.out_sat[0];  hf = bus1.out_sof;
        end
      end
    end
  end

  initial begin : mon4
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && bus4.out_valid && bus4.out_ready) begin
        if (q4.size() == 0) fail_now("unexpected_out4");
        else begin
          e = q4.pop_front();
          check("out4_data",    64'(bus4.out_data), 64'(e.data));
          check("out4_sat",     64'(bus4.out_sat),  64'(e.sat));
          check("out4_latency", 64'(cyc - e.acc),   64'(e.lat));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus1.mode = TE_MODE_PRODUCT;  bus1.inv_ac_in = '0;  bus1.inv_ac_load = 1'b0;
    bus1.in_valid = 1'b0;  bus1.in_sof = 1'b0;  bus1.in_fc = '0;  bus1.out_ready = 1'b1;
    bus4.mode = TE_MODE_PRODUCT;  bus4.inv_ac_in = '0;  bus4.inv_ac_load = 1'b0;
    bus4.in_valid = 1'b0;  bus4.in_sof = 1'b0;  bus4.in_fc = '0;  bus4.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid1", 64'(bus1.out_valid), 64'd0);
    check("rst_out_data1",  64'(bus1.out_data),  64'd0);
    check("rst_out_valid4", 64'(bus4.out_valid), 64'd0);
    check("rst_out_data4",  64'(bus4.out_data),  64'd0);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst1", 64'(bus1.in_ready), 64'd1);
    check("in_ready_after_rst4", 64'(bus4.in_ready), 64'd1);

    // Basic product and transmission: 78*100 = 7800, 16383-7800 = 8583.
    send1(8'd100, 1'b1, TE_MODE_PRODUCT, 1'b1, 14'd78, 14'd7800, 1'b0, 2);
    send1(8'd100, 1'b0, TE_MODE_TRANS,   1'b0, 14'd0,  14'd8583, 1'b0, 2);

    // Saturation and floor.
    send1(8'd255, 1'b1, TE_MODE_PRODUCT, 1'b1, 14'd16383, 14'd16383, 1'b1, 2);
    send1(8'd255, 1'b0, TE_MODE_TRANS,   1'b0, 14'd0,     14'd1638,  1'b1, 2);
    send1(8'd0,   1'b0, TE_MODE_TRANS,   1'b0, 14'd0,     14'd16383, 1'b0, 2);
    drain(1'b0);

    // Backpressure: out_ready low for stream cycles 2..7.
    fork
      begin
        send1(8'd1, 1'b1, TE_MODE_PRODUCT, 1'b1, 14'd100, 14'd100, 1'b0, -1);
        for (int i = 2; i <= 6; i++)
          send1(8'(i), 1'b0, TE_MODE_PRODUCT, 1'b0, 14'd0, 14'(i * 100), 1'b0, -1);
      end
      begin
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", 64'(bus1.in_ready),  64'd0);
        check("bp_out_valid",    64'(bus1.out_valid), 64'd1);
        repeat (3) @(posedge clk);
        #1 bus1.out_ready = 1'b1;
      end
    join
    drain(1'b0);

    // Shadow Inv_Ac: a mid-frame load waits for the next sof beat.
    send1(8'd10, 1'b1, TE_MODE_PRODUCT, 1'b1, 14'd50, 14'd500, 1'b0, 2);
    load1(14'd78);
    send1(8'd10, 1'b0, TE_MODE_PRODUCT, 1'b0, 14'd0, 14'd500, 1'b0, 2);
    send1(8'd10, 1'b1, TE_MODE_PRODUCT, 1'b0, 14'd0, 14'd780, 1'b0, 2);
    // Same-cycle load and sof accept bypass straight to the beat.
    send1(8'd10, 1'b1, TE_MODE_PRODUCT, 1'b1, 14'd50, 14'd500, 1'b0, 2);
    send1(8'd10, 1'b0, TE_MODE_PRODUCT, 1'b0, 14'd0,  14'd500, 1'b0, 2);
    send1(8'd10, 1'b1, TE_MODE_PRODUCT, 1'b1, 14'd78, 14'd780, 1'b0, 2);
    send1(8'd10, 1'b1, TE_MODE_PRODUCT, 1'b0, 14'd0,  14'd780, 1'b0, 2);
    load1(14'd30);
    send1(8'd10, 1'b0, TE_MODE_PRODUCT, 1'b0, 14'd0,  14'd780, 1'b0, 2);
    send1(8'd10, 1'b1, TE_MODE_PRODUCT, 1'b0, 14'd0,  14'd300, 1'b0, 2);
    drain(1'b0);

    // Reset with both stages holding beats.
    bus1.out_ready = 1'b0;
    send1(8'd5, 1'b1, TE_MODE_PRODUCT, 1'b1, 14'd40, 14'd200, 1'b0, -1);
    send1(8'd6, 1'b0, TE_MODE_PRODUCT, 1'b0, 14'd0,  14'd240, 1'b0, -1);
    check("pre_rst_out_valid", 64'(bus1.out_valid), 64'd1);
    check("pre_rst_in_ready",  64'(bus1.in_ready),  64'd0);
    #3 rst = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(bus1.out_valid), 64'd0);
    check("async_rst_out_data",  64'(bus1.out_data),  64'd0);
    check("async_rst_out_sat",   64'(bus1.out_sat),   64'd0);
    check("async_rst_out_sof",   64'(bus1.out_sof),   64'd0);
    q1.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    bus1.out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus1.in_ready), 64'd1);
    @(posedge clk); #1;
    send1(8'd5, 1'b0, TE_MODE_PRODUCT, 1'b0, 14'd0, 14'd0,     1'b0, 2);
    send1(8'd5, 1'b0, TE_MODE_TRANS,   1'b0, 14'd0, 14'd16383, 1'b0, 2);
    drain(1'b0);

    // Four lanes, lane 0 in the low bits.
    send4({8'd0, 8'd1, 8'd128, 8'd255}, 14'd64,
          {14'd0, 14'd64, 14'd8192, 14'd16320}, 4'b0000);
    send4({8'd0, 8'd1, 8'd100, 8'd255}, 14'd128,
          {14'd0, 14'd128, 14'd12800, 14'd16383}, 4'b0001);
    drain(1'b1);

    check("q1_empty", 64'(q1.size()), 64'd0);
    check("q4_empty", 64'(q4.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/te_multiplier_pipe.md
# te_multiplier_pipe

Parametrised transmission-estimate multiplier for the dehaze datapath. It computes ω·Fc/Ac for LANES pixels per beat and saturates instead of wrapping. Optionally it outputs the clamped transmission t = 1 − ω·Fc/Ac, floored at T0. It sits between the dark-channel filter and the scene-recovery stage, uses a ready/valid pipeline, and double-buffers the inverted atmospheric light so the value changes only at frame boundaries.

## Interface
- LANES, 1, pixels processed per beat
- FC_W, 8, filter-result width (unsigned integer)
- FRAC_W, 14, fractional width of Inv_Ac and the output (Q0.FRAC_W)
- T0, 1638, transmission floor in Q0.FRAC_W (≈0.1 at FRAC_W=14)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- mode  in  1  0 = product ω·Fc/Ac, 1 = transmission; captured per accepted beat
- inv_ac_in  in  FRAC_W  new scaled inverted atmospheric light ω/Ac, Q0.FRAC_W
- inv_ac_load  in  1  strobe; writes inv_ac_in into the pending register
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_sof  in  1  beat is first of a frame
- in_fc  in  LANES*FC_W  filter results; lane i at bits [i*FC_W +: FC_W]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_sof  out  1  sof delayed with its beat
- out_data  out  LANES*FRAC_W  per-lane result, Q0.FRAC_W
- out_sat  out  LANES  per-lane flag: product saturated

## Operation
- **Active/pending Inv_Ac**
  - inv_ac_load writes the pending register and sets pend_flag.
  - When a beat with in_sof=1 is accepted and pend_flag=1, active ← pending and pend_flag clears.
  - That sof beat already uses the new value.
  - If inv_ac_load and the sof accept occur in the same cycle, inv_ac_in is bypassed directly to active and to that beat. Pending ends equal to inv_ac_in; pend_flag=0.
  - Non-sof beats always use the active value.
- **Stage 1:** per lane p = in_fc × active_inv, width FC_W+FRAC_W. mode and sof are registered alongside.
- **Stage 2 (per lane)**
  - Saturation: sat = |p[FC_W+FRAC_W-1:FRAC_W]|.
  - ps = sat ? 2^FRAC_W−1 : p[FRAC_W-1:0].
  - mode 0: out = ps.
  - mode 1: t = (2^FRAC_W−1) − ps, then out = max(t, T0).
  - out_sat = sat in both modes.
- **Flow control**
  - s2 loads when !s2_valid || out_ready.
  - s1 loads when !s1_valid || s2 loads.
  - in_ready = !s1_valid || s2 loads.
  - No beat is dropped or duplicated; order is preserved.
- Changing mode mid-stream affects only beats accepted after the change.

## Timing
- Latency is 2 cycles from accept to out_valid with no backpressure. Throughput is 1 beat/cycle.
- out_data, out_sof, out_sat and out_valid are registered and hold stable while out_valid && !out_ready.
- in_ready is combinational from out_ready and the valid bits.
- **Reset (rst=0, asynchronous, any time including mid-frame)**
  - s1_valid, s2_valid = 0, so out_valid=0.
  - out_data, out_sat, out_sof = 0.
  - active and pending Inv_Ac = 0; pend_flag = 0.
  - In-flight beats are discarded.
  - in_ready is 1 from the first cycle after release.
- After reset and before any load, active=0: mode 0 yields 0; mode 1 yields 2^FRAC_W−1.
- When the pipeline is full and out_ready=0, in_ready=0.
- When s2 is empty, the pipeline accepts regardless of out_ready.

## Structure
- **Shared package te_pkg**
  - default FRAC_W = 14
  - default T0 = 1638
  - mode encoding as a typedef: TE_MODE_PRODUCT = 0, TE_MODE_TRANS = 1
- **Sub-module te_lane:** one lane's saturate/transmit/floor logic, instantiated LANES times.
- The top level owns the valid/ready control and the Inv_Ac shadow registers.

## Test plan
- **Basic product:** LANES=1, load 78 with an sof beat, Fc=100, mode 0.
  - out_data=7800, out_sat=0, 2 cycles after accept.
  - Same beat in mode 1 gives 8583.
- **Saturation and floor:** Inv_Ac=16383, Fc=255.
  - Mode 0: out_data=16383, out_sat=1.
  - Mode 1: out_data=1638 (floor), out_sat=1.
  - Fc=0 in mode 1: out_data=16383, out_sat=0.
- **Backpressure:** stream 6 beats Fc=1..6 (Inv_Ac=100) with out_ready low for cycles 2–7.
  - in_ready drops once 2 beats are held.
  - out_data is stable while stalled.
  - Outputs 100..600 appear in order, none lost or duplicated.
- **Shadow Inv_Ac:** active=50; load 78 mid-frame, then send Fc=10 non-sof, then Fc=10 with sof.
  - Outputs are 500 then 780.
  - Repeat with the load in the same cycle as the sof accept: 780 on that beat.
- **Reset mid-stream:** assert rst low with both stages valid.
  - out_valid=0 and out_data=0 immediately, asynchronously.
  - After release: in_ready=1; a beat Fc=5 with no load gives 0 in mode 0.
- **Multi-lane:** LANES=4, Inv_Ac=64, Fc={255,128,1,0}.
  - out_data={16320,8192,64,0}, out_sat=0000.
  - With Inv_Ac=128, lane 0 gives 16383 and out_sat=0001.
